// File: rtl/trx_window_sched_if.sv
// Signal bundle between the SPI configuration decoder (master) and the
// RX/TX window scheduler (slave).
interface trx_window_sched_if;
    logic        en;
    logic [15:0] rx_len;
    logic        rx_arm;
    logic [15:0] tx_len;
    logic        tx_arm;
    logic        rx_en;
    logic        tx_en;
    logic        rx_done;
    logic        tx_done;
    logic        busy;
    logic [1:0]  state_o;
    logic [7:0]  frame_cnt;

    modport master (
        output en, rx_len, rx_arm, tx_len, tx_arm,
        input  rx_en, tx_en, rx_done, tx_done, busy, state_o, frame_cnt
    );

    modport slave (
        input  en, rx_len, rx_arm, tx_len, tx_arm,
        output rx_en, tx_en, rx_done, tx_done, busy, state_o, frame_cnt
    );
endinterface

// File: rtl/trx_window_sched.sv
// Time-division scheduler: alternates RX and TX windows separated by a fixed
// guard interval, latching window lengths at window start.
module trx_window_sched #(
    parameter int GUARD_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    trx_window_sched_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RX    = 2'd1,
        S_GUARD = 2'd2,
        S_TX    = 2'd3
    } state_t;

    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [7:0]  r_gcnt, w_gcnt_nxt;
    logic [7:0]  r_frame, w_frame_nxt;
    logic        r_last, w_last_nxt;
    logic        r_rx_done, w_rx_done_nxt;
    logic        r_tx_done, w_tx_done_nxt;

    logic        w_rx_elig, w_tx_elig, w_tx_first;
    state_t      w_pick;
    logic [15:0] w_pick_len;

    assign w_rx_elig = bus.rx_arm && (bus.rx_len != 16'd0);
    assign w_tx_elig = bus.tx_arm && (bus.tx_len != 16'd0);
    // r_last: 0 = last window was RX, 1 = TX. TX is preferred only after an RX window.
    assign w_tx_first = (r_state == S_GUARD) && !r_last;

    always_comb begin
        w_pick     = S_IDLE;
        w_pick_len = 16'd0;
        if (w_tx_first) begin
            if (w_tx_elig) begin
                w_pick     = S_TX;
                w_pick_len = bus.tx_len;
            end else if (w_rx_elig) begin
                w_pick     = S_RX;
                w_pick_len = bus.rx_len;
            end
        end else begin
            if (w_rx_elig) begin
                w_pick     = S_RX;
                w_pick_len = bus.rx_len;
            end else if (w_tx_elig) begin
                w_pick     = S_TX;
                w_pick_len = bus.tx_len;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gcnt_nxt    = r_gcnt;
        w_last_nxt    = r_last;
        w_frame_nxt   = r_frame;
        w_rx_done_nxt = 1'b0;
        w_tx_done_nxt = 1'b0;
        if (!bus.en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
            w_gcnt_nxt  = 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = w_pick;
                    w_cnt_nxt   = w_pick_len;
                end
                S_RX, S_TX: begin
                    if (r_cnt == 16'd1) begin
                        w_state_nxt = S_GUARD;
                        w_cnt_nxt   = 16'd0;
                        w_gcnt_nxt  = GUARD_LD;
                        w_last_nxt  = (r_state == S_TX);
                        if (r_state == S_TX) begin
                            w_tx_done_nxt = 1'b1;
                            w_frame_nxt   = r_frame + 8'd1;
                        end else begin
                            w_rx_done_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                S_GUARD: begin
                    if (r_gcnt == 8'd1) begin
                        w_state_nxt = w_pick;
                        w_cnt_nxt   = w_pick_len;
                        w_gcnt_nxt  = 8'd0;
                    end else begin
                        w_gcnt_nxt = r_gcnt - 8'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_gcnt    <= 8'd0;
            r_last    <= 1'b0;
            r_frame   <= 8'd0;
            r_rx_done <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_last    <= w_last_nxt;
            r_frame   <= w_frame_nxt;
            r_rx_done <= w_rx_done_nxt;
            r_tx_done <= w_tx_done_nxt;
        end
    end

    assign bus.rx_en     = (r_state == S_RX);
    assign bus.tx_en     = (r_state == S_TX);
    assign bus.rx_done   = r_rx_done;
    assign bus.tx_done   = r_tx_done;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.state_o   = r_state;
    assign bus.frame_cnt = r_frame;
endmodule

// File: doc/trx_window_sched.md
# trx_window_sched

Time-division window scheduler that turns the decoded SPI configuration (RX/TX window lengths and their arm flags) into mutually exclusive `rx_en`/`tx_en` windows for the transceiver front-end. It sits directly downstream of the SPI configuration decoder. It alternates RX and TX windows, separated by a fixed guard interval, and counts completed frames. Register values are latched at the start of each window, so SPI writes never corrupt a window in flight.

## Interface
- `GUARD_CYCLES`, default 4: idle cycles between consecutive windows. Legal range is 1..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  scheduler enable. Low forces an abort to IDLE.
- `rx_len`  in  16  RX window length in cycles (from `ext_counter_value_RX`).
- `rx_arm`  in  1  RX windows permitted (from `ext_counter_flag_RX`).
- `tx_len`  in  16  TX window length in cycles (from `ext_counter_value_TX`).
- `tx_arm`  in  1  TX windows permitted (from `ext_counter_flag_TX`).
- `rx_en`  out  1  RX window active.
- `tx_en`  out  1  TX window active.
- `rx_done`  out  1  one-cycle pulse when an RX window completes.
- `tx_done`  out  1  one-cycle pulse when a TX window completes.
- `busy`  out  1  state != IDLE.
- `state_o`  out  2  current state: IDLE=0, RX=1, GUARD=2, TX=3.
- `frame_cnt`  out  8  completed TX windows, modulo 256.

## Operation
- A window is *eligible* when its arm is high and its length is non-zero. Lengths are sampled only at window start.
- **IDLE.** The scheduler waits for `en` high. If RX is eligible it loads `cnt <= rx_len` and goes to RX. Otherwise, if TX is eligible, it loads `cnt <= tx_len` and goes to TX. Otherwise it stays in IDLE. RX has priority from IDLE.
- **RX.**
  - `rx_en` = 1. `cnt` decrements each cycle.
  - On the cycle where `cnt == 1`, the next state is GUARD. `last <= RX`, and the guard counter loads `GUARD_CYCLES`.
- **TX.** Identical to RX, but uses `tx_en` and sets `last <= TX`.
- **GUARD.**
  - Both enables are 0 for exactly `GUARD_CYCLES` cycles.
  - On the final guard cycle the next window is selected, with the opposite window preferred:
    - If last was RX: TX if eligible, else RX if eligible, else IDLE.
    - If last was TX: RX if eligible, else TX if eligible, else IDLE.
  - The length of the chosen window is loaded into `cnt` at that edge.
- **Done pulses.** `rx_done`/`tx_done` pulse in the first GUARD cycle after the window, i.e. one cycle after the last enable cycle.
- **Frame counter.** `frame_cnt` increments on the same edge that raises `tx_done`. It wraps 255 to 0.
- **Arm deasserted mid-window.** The current window still completes at its full latched length, with its done pulse. The window is only excluded from subsequent selection.
- **Length changed mid-window.** Ignored until that window next starts.
- **`en` low in any state.**
  - The next edge goes to IDLE and clears `cnt` and the guard counter.
  - `rx_en`/`tx_en` drop on that edge.
  - No done pulse is generated and `frame_cnt` does not change.
  - `en` has priority over every other transition.
- **Mutual exclusion.** `rx_en` and `tx_en` are never high in the same cycle, and are never high in GUARD or IDLE.
- **Reset.** Every output resets to 0, including `state_o` (IDLE) and `frame_cnt`. Internal `cnt`, guard counter and `last` also reset to 0. Reset asserted mid-window drops the enables immediately (asynchronous).

## Timing
- Start latency: `en` and eligibility sampled high at edge k gives `rx_en` (or `tx_en`) high from edge k+1.
- Window width: a window of length N keeps its enable high for exactly N cycles.
- Guard width: `GUARD_CYCLES` cycles.
- Window-to-window period: N + `GUARD_CYCLES` cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `rx_len` and `tx_len` are 16-bit, so the maximum window is 65535 cycles.
- A length of 0 is never started. It is treated as not eligible.
- Inputs are synchronous to `clk`. The upstream decoder already synchronises its inputs.

## Test plan
- **RX only.** `rx_arm`=1, `rx_len`=3, `tx_arm`=0, GUARD=4 -> `rx_en` repeats 3 high / 4 low. `rx_done` pulses in each first-low cycle. `frame_cnt` stays 0.
- **Both armed.** `rx_len`=2, `tx_len`=5 -> pattern RX2, G4, TX5, G4, RX2, repeating. `frame_cnt` goes 1, 2, … after each TX. The enables never overlap.
- **Zero length.** `tx_arm`=1 with `tx_len`=0 and RX armed with length 3 -> only RX windows occur and `tx_en` never rises. Writing `tx_len`=4 mid-RX inserts TX after the next guard.
- **Abort.** `en` dropped on the 2nd cycle of a 10-cycle TX window -> `tx_en` is low the next cycle, `state_o`=0, no `tx_done`, `frame_cnt` unchanged. Re-raising `en` restarts with RX if RX is eligible.
- **Arm drop / length change.** `rx_arm` cleared and `rx_len` changed from 8 to 2 during an 8-cycle RX window -> the window still lasts 8 cycles with `rx_done`. The next window is TX or IDLE, never RX.
- **Wrap and reset.** 256 TX-only windows (`tx_len`=1, GUARD=1) -> `frame_cnt` wraps to 0. `rst` asserted mid-window -> all outputs are 0 immediately, and the scheduler is IDLE after release.
